alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Sits directly downstream of the ALU and owns the 4-bit status register.
- Captures each ALU result and flag vector under a valid/ready handshake.
- Merges the flags into the status register under a per-instruction mask, and feeds the current flags back to ALU Cflags.
- Queues results tagged with a destination address in a small FIFO, then drains them to data memory (DMem.DI) one write per cycle under memory back-pressure.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- ADDR_W, 8, data-memory address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ALU result valid (from control unit)
- in_ready  out  1  stage can accept a result this cycle
- alu_out  in  8  ALU Out
- alu_flags  in  4  ALU flags {Z,C,S,O}
- flag_mask  in  4  per-bit update enable for status register, same bit order
- do_write  in  1  1 = store alu_out to memory; 0 = flags-only (compare/test)
- wr_addr  in  ADDR_W  destination address for the store
- sr_load  in  1  direct status-register load (control unit, e.g. flag restore)
- sr_wdata  in  4  value for sr_load
- cflags  out  4  current status register, to ALU Cflags
- mem_we  out  1  write request to data memory
- mem_addr  out  ADDR_W  write address
- mem_di  out  8  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  FIFO non-empty (stores pending)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - status register = 4'b0000; cflags = 0.
  - FIFO empty: rd_ptr = wr_ptr = count = 0.
  - mem_we = 0, busy = 0; mem_addr and mem_di = 0.
  - in_ready = 1 in the cycle after reset is released.
- Accept: acc = in_valid & in_ready, with in_ready = (count != DEPTH). No same-cycle pass-through when full.
- Status register update:
  - On acc, registered: SR <= (base & ~flag_mask) | (alu_flags & flag_mask), where base = sr_load ? sr_wdata : SR.
  - sr_load without acc: SR <= sr_wdata.
  - Neither: SR holds.
  - When both occur in the same cycle, the ALU flags win on masked bits and sr_wdata wins on the rest.
- Flag latency: without the optional feature, cflags = SR, so updated flags are visible one cycle after acc.
- Push: on acc & do_write, write {wr_addr, alu_out} at wr_ptr; wr_ptr increments, wrapping modulo DEPTH. acc with do_write = 0 pushes nothing.
- Drain:
  - mem_we = (count != 0); mem_addr and mem_di = head entry (combinational from FIFO read port).
  - Pop when mem_we & mem_ready; rd_ptr increments, wrapping modulo DEPTH.
  - mem_addr, mem_di and mem_we stay stable while mem_ready = 0.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Simultaneous push and pop at count = DEPTH - 1 or 1 is legal.
- Full: when count == DEPTH, in_ready = 0. A pop in that cycle re-opens in_ready next cycle.
- Empty: when count == 0, mem_we = 0 and mem_addr/mem_di hold their last value (don't-care for checking).
- busy = (count != 0).
- Ordering: memory writes occur strictly in acceptance order.
- Inputs with in_valid = 0 are ignored, except sr_load.
- Reset mid-operation: pending FIFO entries are discarded with no further mem_we and SR is cleared, both in the reset cycle.

Optional Feature:
- Macro: ALU_WB_FLAG_BYPASS_EN.
- Defined: cflags combinationally shows the next SR value in the acc and sr_load cycle, giving zero-latency flag forwarding for back-to-back ALU ops (e.g. chained decrement/branch).
- Undefined: cflags = SR (registered), one-cycle latency as above.
- SR contents and FIFO behaviour are identical in both builds.

Decomposition:
- Shared package:
  - flag bit-index constants FLAG_Z = 3, FLAG_C = 2, FLAG_S = 1, FLAG_O = 0
  - flags_t (4-bit) typedef
  - default DEPTH and ADDR_W constants (shared with control unit and ALU)
- Sub-module: wb_fifo, a generic DEPTH x (ADDR_W+8) synchronous FIFO with push/pop/count/full/empty. The top level holds the status register, merge logic and handshake glue.

Test Plan:
1. Reset then idle: after rst, cflags = 0, mem_we = 0, in_ready = 1, busy = 0.
2. Single store: acc alu_out = 8'h3C, flags = 4'b0100, mask = 4'hF, wr_addr = 8'h10, mem_ready = 1 → cflags = 4'b0100 next cycle; mem_we = 1 with mem_addr = 8'h10, mem_di = 8'h3C for one cycle; busy then returns to 0.
3. Mask merge: SR = 4'b1010, acc flags = 4'b0101, mask = 4'b0011, sr_load = 0 → SR = 4'b1001. Same cycle with sr_load = 1, sr_wdata = 4'b0000 → SR = 4'b0001.
4. Back-pressure and full: mem_ready = 0, push 5 stores (DEPTH = 4) → in_ready = 0 after the 4th; the 5th is held. Release mem_ready → writes emerge in order, addresses 0,1,2,3, then the 5th; pointers wrap correctly.
5. Flags-only op: acc with do_write = 0, flags = 4'b1000, mask = 4'b1000 → SR.Z = 1, no mem_we, count unchanged.
6. Reset mid-drain: 3 entries pending, assert rst for one cycle → mem_we = 0 and cflags = 0 in the following cycle, with no residual writes. With ALU_WB_FLAG_BYPASS_EN defined, cflags = new flags in the acc cycle itself.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: flag bit positions, the flag
// vector type, default sizing and the masked flag-merge helper.
package alu_writeback_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_ADDR_W = 8;

    typedef logic [3:0] flags_t;

    // Masked bits take the new flags; the rest keep the base value.
    function automatic flags_t merge_flags(input flags_t base, input flags_t new_flags,
                                           input flags_t mask);
        return (base & ~mask) | (new_flags & mask);
    endfunction

endpackage

// File: rtl/alu_writeback_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with a combinational head read port.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: status register with masked flag merge, and a store FIFO
// draining to data memory. Optional macro ALU_WB_FLAG_BYPASS_EN forwards next SR to cflags.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        alu_out,
    input  logic [3:0]        alu_flags,
    input  logic [3:0]        flag_mask,
    input  logic              do_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              sr_load,
    input  logic [3:0]        sr_wdata,
    output logic [3:0]        cflags,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_di,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int ENTRY_W = ADDR_W + 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    flags_t             sr_q, sr_d;
    flags_t             sr_base;
    logic               acc;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;

    assign in_ready = ~full;
    assign acc      = in_valid & in_ready;
    assign push     = acc & do_write;
    assign mem_we   = ~empty;
    assign pop      = mem_we & mem_ready;
    assign busy     = (count != '0);

    // Outputs read zero while idle so they are clean straight out of reset.
    assign mem_addr = mem_we ? head[ENTRY_W-1:8] : '0;
    assign mem_di   = mem_we ? head[7:0] : '0;

    always_comb begin
        sr_base = sr_load ? sr_wdata : sr_q;
        sr_d    = sr_base;
        if (acc) sr_d = merge_flags(sr_base, alu_flags, flag_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

`ifdef ALU_WB_FLAG_BYPASS_EN
    assign cflags = sr_d;
`else
    assign cflags = sr_q;
`endif

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({wr_addr, alu_out}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule
